// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - RV32I five-stage hazard, forwarding and memory wait-state controller
module hazard_controller #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_D,
    input  logic [4:0]       rs2_D,
    input  logic [4:0]       rs1_E,
    input  logic [4:0]       rs2_E,
    input  logic [4:0]       rd_E,
    input  logic [4:0]       rd_M,
    input  logic [4:0]       rd_W,
    input  logic             ctrl_result_E,
    input  logic             ctrl_register_file_WE_M,
    input  logic             ctrl_register_file_WE_W,
    input  logic             pc_src_E,
    input  logic             mem_req_M,
    input  logic             mem_ready,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic [1:0]       forward_A_E,
    output logic [1:0]       forward_B_E,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WCW = $clog2(MEM_TIMEOUT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t         state;
    state_t         state_next;
    logic [WCW-1:0] wait_cnt;
    logic           timeout;
    logic           mem_stall;
    logic           lw_stall;

    // M-stage result is younger than W, so it wins when both match
    always_comb begin
        forward_A_E = 2'b00;
        if (ctrl_register_file_WE_M && rd_M != 5'd0 && rd_M == rs1_E)
            forward_A_E = 2'b10;
        else if (ctrl_register_file_WE_W && rd_W != 5'd0 && rd_W == rs1_E)
            forward_A_E = 2'b01;
    end

    always_comb begin
        forward_B_E = 2'b00;
        if (ctrl_register_file_WE_M && rd_M != 5'd0 && rd_M == rs2_E)
            forward_B_E = 2'b10;
        else if (ctrl_register_file_WE_W && rd_W != 5'd0 && rd_W == rs2_E)
            forward_B_E = 2'b01;
    end

    assign lw_stall = ctrl_result_E && (rd_E != 5'd0) && (rd_E == rs1_D || rd_E == rs2_D);
    assign timeout  = (state == ST_WAIT) && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // The request is not re-examined in WAIT: M is frozen so it cannot change
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (mem_req_M && !mem_ready) state_next = ST_WAIT;
            ST_WAIT: if (mem_ready || timeout)    state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Reset gates the freeze so an aborted access releases the pipeline at once
    always_comb begin
        mem_stall = !rst && (((state == ST_IDLE) && mem_req_M && !mem_ready) ||
                             ((state == ST_WAIT) && !mem_ready && !timeout));
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_W = 1'b0;
        if (mem_stall) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            stall_M = 1'b1;
            flush_W = 1'b1;
        end else if (pc_src_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else if (lw_stall) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end
    end

    // Held at zero in IDLE, so it is already clear on the first WAIT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (state == ST_IDLE)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem_error <= 1'b0;
        else if (timeout && !mem_ready)
            mem_error <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (stall_F && stall_count != {CNT_W{1'b1}})
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scoreboard bench for hazard_controller
module tb_hazard_controller;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic             ctrl_result_E, we_M, we_W, pc_src_E, mem_req_M, mem_ready;
    logic             stall_F, stall_D, stall_E, stall_M;
    logic             flush_D, flush_E, flush_W;
    logic [1:0]       forward_A_E, forward_B_E;
    logic             mem_error;
    logic [CNT_W-1:0] stall_count;

    hazard_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
        .ctrl_result_E(ctrl_result_E),
        .ctrl_register_file_WE_M(we_M), .ctrl_register_file_WE_W(we_W),
        .pc_src_E(pc_src_E), .mem_req_M(mem_req_M), .mem_ready(mem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
        .forward_A_E(forward_A_E), .forward_B_E(forward_B_E),
        .mem_error(mem_error), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [3:0] st;
        logic [2:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       err;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vec_idx = 0;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL v%0d %s: got %0d expected %0d", idx, name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall{F,D,E,M}", e.idx, int'({stall_F, stall_D, stall_E, stall_M}), int'(e.st));
            chk("flush{D,E,W}", e.idx, int'({flush_D, flush_E, flush_W}), int'(e.fl));
            chk("forward_A_E", e.idx, int'(forward_A_E), int'(e.fa));
            chk("forward_B_E", e.idx, int'(forward_B_E), int'(e.fb));
            chk("mem_error", e.idx, int'(mem_error), int'(e.err));
            chk("stall_count", e.idx, int'(stall_count), e.cnt);
        end
    end

    task automatic clear();
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
        ctrl_result_E = 0; we_M = 0; we_W = 0; pc_src_E = 0; mem_req_M = 0; mem_ready = 0;
    endtask

    task automatic mem(input logic req, input logic rdy);
        clear();
        mem_req_M = req;
        mem_ready = rdy;
    endtask

    // Push the expectation for the current input set, then advance one cycle
    task automatic vec(input logic [3:0] st, input logic [2:0] fl, input logic [1:0] fa,
                       input logic [1:0] fb, input logic err, input int cnt);
        exp_t e;
        e.idx = vec_idx; e.st = st; e.fl = fl; e.fa = fa; e.fb = fb; e.err = err; e.cnt = cnt;
        exp_q.push_back(e);
        vec_idx++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear();
        @(posedge clk);
        #1;
        vec(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0);
        rst = 1'b0;

        // forwarding
        we_M = 1; rd_M = 5; we_W = 1; rd_W = 5; rs1_E = 5; rs2_E = 0;
        vec(4'b0000, 3'b000, 2'b10, 2'b00, 0, 0);
        we_M = 0;
        vec(4'b0000, 3'b000, 2'b01, 2'b00, 0, 0);
        clear(); we_M = 1; we_W = 1;
        vec(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0);
        we_M = 1; rd_M = 5; we_W = 1; rd_W = 9; rs1_E = 9; rs2_E = 5;
        vec(4'b0000, 3'b000, 2'b01, 2'b10, 0, 0);

        // load-use
        clear(); ctrl_result_E = 1; rd_E = 7; rs2_D = 7;
        vec(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0);
        rs1_D = 7; rs2_D = 0;
        vec(4'b1100, 3'b010, 2'b00, 2'b00, 0, 1);
        rd_E = 0; rs1_D = 0;
        vec(4'b0000, 3'b000, 2'b00, 2'b00, 0, 2);

        // branch, branch+load-use, branch under memory freeze
        clear(); pc_src_E = 1;
        vec(4'b0000, 3'b110, 2'b00, 2'b00, 0, 2);
        ctrl_result_E = 1; rd_E = 7; rs1_D = 7;
        vec(4'b0000, 3'b110, 2'b00, 2'b00, 0, 2);
        clear(); pc_src_E = 1; mem_req_M = 1;
        vec(4'b1111, 3'b001, 2'b00, 2'b00, 0, 2);
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 0, 3);
        mem(1, 1); vec(4'b0000, 3'b000, 2'b00, 2'b00, 0, 4);

        // three wait cycles
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 0, 4);
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 0, 5);
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 0, 6);
        mem(1, 1); vec(4'b0000, 3'b000, 2'b00, 2'b00, 0, 7);
        mem(0, 0); vec(4'b0000, 3'b000, 2'b00, 2'b00, 0, 7);

        // zero wait cycles
        mem(1, 1); vec(4'b0000, 3'b000, 2'b00, 2'b00, 0, 7);
        mem(0, 0); vec(4'b0000, 3'b000, 2'b00, 2'b00, 0, 7);

        // ready arrives in the timeout cycle: completion, no error
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 0, 7);
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 0, 8);
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 0, 9);
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 0, 10);
        mem(1, 1); vec(4'b0000, 3'b000, 2'b00, 2'b00, 0, 11);
        mem(0, 0); vec(4'b0000, 3'b000, 2'b00, 2'b00, 0, 11);

        // timeout
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 0, 11);
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 0, 12);
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 0, 13);
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 0, 14);
        mem(1, 0); vec(4'b0000, 3'b000, 2'b00, 2'b00, 0, 15);
        mem(0, 0); vec(4'b0000, 3'b000, 2'b00, 2'b00, 1, 15);

        // later access still works, error sticky, counter saturated
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 1, 15);
        mem(1, 1); vec(4'b0000, 3'b000, 2'b00, 2'b00, 1, 15);
        mem(0, 0); vec(4'b0000, 3'b000, 2'b00, 2'b00, 1, 15);

        // asynchronous reset during the second wait cycle
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 1, 15);
        mem(1, 0); vec(4'b1111, 3'b001, 2'b00, 2'b00, 1, 15);
        mem(1, 0);
        #2;
        rst = 1'b1;
        vec(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0);
        rst = 1'b0;
        mem(0, 0); vec(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
